// File: rtl/timer_counter_if.sv
// Bus-side interface of the timer: word-select register port plus interrupt line.
interface timer_counter_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    // Bridge / CPU side drives the access, reads data and irq back.
    modport master (output addr, output we, output din, input dout, input irq);
    // Timer side.
    modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, four-state
// control FSM, one-shot (latched irq) or periodic (one-cycle pulse) expiry.
module timer_counter (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;      // {IM, Mode[1:0], En}
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic        wr_ctrl, wr_preset;
    logic        en, periodic;
    logic [31:0] rd_data;

    assign wr_ctrl   = bus.we && (bus.addr == A_CTRL);
    assign wr_preset = bus.we && (bus.addr == A_PRESET);
    assign en        = ctrl_q[0];
    assign periodic  = (ctrl_q[2:1] == 2'b01);

    // FSM next state and register updates; CPU writes are applied last so
    // they win over same-edge FSM updates to CTRL.En and irq_flag.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        case (state_q)
            IDLE: begin
                if (en) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // 0 and 1 both expire, so PRESET=0 acts like PRESET=1
                    count_d = '0;
                    flag_d  = 1'b1;
                    state_d = INT;
                end
            end
            INT: begin
                if (periodic) begin
                    flag_d  = 1'b0;
                    state_d = LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_ctrl)   ctrl_d   = bus.din[3:0];
        if (wr_preset) preset_d = bus.din;
        // Any CTRL/PRESET write acknowledges the interrupt.
        if (wr_ctrl || wr_preset) flag_d = 1'b0;
    end

    // State and register storage, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Zero-latency read mux; unused CTRL bits and addr 3 read as zero.
    always_comb begin
        rd_data = '0;
        case (bus.addr)
            A_CTRL:   rd_data = {28'd0, ctrl_q};
            A_PRESET: rd_data = preset_q;
            A_COUNT:  rd_data = count_q;
            default:  rd_data = '0;
        endcase
    end

    assign bus.dout = rd_data;
    assign bus.irq  = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: one clock cycle per vector, each vector
// optionally writes a register, then reads one register and checks irq.
module tb_timer_counter;
    logic clk;
    logic reset;

    timer_counter_if bus ();

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [1:0]  raddr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic w, input logic [1:0] a, input logic [31:0] d,
                                input logic [1:0] ra, input logic [31:0] e, input logic i);
        vec_t v;
        v.we = w; v.addr = a; v.din = d; v.raddr = ra; v.exp_dout = e; v.exp_irq = i;
        vecs.push_back(v);
    endfunction

    function automatic void rd(input logic [1:0] ra, input logic [31:0] e, input logic i);
        add(1'b0, 2'd0, 32'd0, ra, e, i);
    endfunction

    // Combinational check of the current state through the read port.
    task automatic chk(input string name, input logic [1:0] ra, input logic [31:0] e, input logic i);
        bus.addr = ra;
        #1;
        n_vec++;
        if (bus.dout !== e || bus.irq !== i) begin
            n_bad++;
            $display("FAIL %s: addr%0d dout=%h irq=%b, expected dout=%h irq=%b",
                     name, ra, bus.dout, bus.irq, e, i);
        end
    endtask

    // One cycle: present access before the edge, then read back after it.
    task automatic step(input string name, input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic [1:0] ra, input logic [31:0] e, input logic i);
        @(negedge clk);
        bus.we = w; bus.addr = a; bus.din = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0; bus.din = '0;
        chk(name, ra, e, i);
    endtask

    initial begin
        // one-shot, PRESET=3
        add(1, 1, 32'd3, 1, 32'd3, 0);
        add(1, 0, 32'h9, 0, 32'h9, 0);
        rd(2, 0, 0); rd(2, 3, 0); rd(2, 2, 0); rd(2, 1, 0);
        rd(2, 0, 1); rd(0, 32'h8, 1); rd(2, 0, 1);
        add(1, 0, 32'h8, 0, 32'h8, 0);
        // periodic, PRESET=2: LOAD, CNT 2, CNT 1, INT (irq) x5
        add(1, 1, 32'd2, 1, 32'd2, 0);
        add(1, 0, 32'hB, 0, 32'hB, 0);
        for (int p = 0; p < 5; p++) begin
            rd(2, 0, 0); rd(2, 2, 0); rd(2, 1, 0); rd(2, 0, 1);
        end
        add(1, 0, 32'h0, 0, 32'h0, 0);
        rd(2, 2, 0); rd(2, 2, 0); rd(2, 2, 0);
        // disable mid-count, then re-enable reloads from PRESET
        add(1, 1, 32'd10, 1, 32'd10, 0);
        add(1, 0, 32'h9, 0, 32'h9, 0);
        rd(2, 2, 0); rd(2, 10, 0); rd(2, 9, 0); rd(2, 8, 0); rd(2, 7, 0);
        add(1, 0, 32'h8, 2, 32'd6, 0);
        rd(2, 6, 0); rd(2, 6, 0); rd(0, 32'h8, 0);
        add(1, 0, 32'h9, 2, 32'd6, 0);
        rd(2, 6, 0); rd(2, 10, 0);
        add(1, 0, 32'h0, 2, 32'd9, 0);
        rd(2, 9, 0); rd(2, 9, 0);
        // masked one-shot, then setting IM does not expose a stale flag
        add(1, 1, 32'd1, 1, 32'd1, 0);
        add(1, 0, 32'h1, 0, 32'h1, 0);
        rd(2, 9, 0); rd(2, 1, 0); rd(2, 0, 0); rd(0, 32'h0, 0);
        add(1, 0, 32'h8, 0, 32'h8, 0);
        // PRESET=0: irq two cycles after LOAD, acknowledged by a PRESET write
        add(1, 1, 32'd0, 1, 32'd0, 0);
        add(1, 0, 32'h9, 0, 32'h9, 0);
        rd(2, 0, 0); rd(2, 0, 0); rd(2, 0, 1); rd(0, 32'h8, 1);
        add(1, 1, 32'd5, 1, 32'd5, 0);
        // writes to COUNT and addr 3 are ignored
        add(1, 2, 32'hFFFF_FFFF, 2, 32'd0, 0);
        add(1, 3, 32'hFFFF_FFFF, 3, 32'd0, 0);
        rd(0, 32'h8, 0); rd(1, 32'd5, 0); rd(2, 0, 0);
        // PRESET write on the expiry edge beats the flag set
        add(1, 0, 32'h9, 0, 32'h9, 0);
        rd(2, 0, 0); rd(2, 5, 0); rd(2, 4, 0); rd(2, 3, 0); rd(2, 2, 0); rd(2, 1, 0);
        add(1, 1, 32'd2, 2, 32'd0, 0);
        rd(0, 32'h8, 0);
        // CTRL write in INT beats the FSM clearing En
        add(1, 0, 32'h9, 0, 32'h9, 0);
        rd(2, 0, 0); rd(2, 2, 0); rd(2, 1, 0); rd(2, 0, 1);
        add(1, 0, 32'h9, 0, 32'h9, 0);
        rd(2, 0, 0); rd(2, 2, 0);
        add(1, 0, 32'h0, 2, 32'd1, 0);
        rd(2, 1, 0);

        // reset values, applied asynchronously at time 0
        reset = 1'b0;
        bus.we = 1'b0; bus.addr = 2'd0; bus.din = '0;
        #2;
        chk("por_ctrl",   0, 32'd0, 0);
        chk("por_preset", 1, 32'd0, 0);
        chk("por_count",  2, 32'd0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            step($sformatf("vec%0d", k), vecs[k].we, vecs[k].addr, vecs[k].din,
                 vecs[k].raddr, vecs[k].exp_dout, vecs[k].exp_irq);
        end

        // reset while counting with COUNT=5
        step("rst_preset", 1, 1, 32'd8, 1, 32'd8, 0);
        step("rst_ctrl",   1, 0, 32'h9, 0, 32'h9, 0);
        step("rst_load",   0, 0, 32'd0, 2, 32'd1, 0);
        step("rst_c8",     0, 0, 32'd0, 2, 32'd8, 0);
        step("rst_c7",     0, 0, 32'd0, 2, 32'd7, 0);
        step("rst_c6",     0, 0, 32'd0, 2, 32'd6, 0);
        step("rst_c5",     0, 0, 32'd0, 2, 32'd5, 0);
        reset = 1'b0;
        chk("rst_ctrl0",   0, 32'd0, 0);
        chk("rst_preset0", 1, 32'd0, 0);
        chk("rst_count0",  2, 32'd0, 0);
        @(posedge clk);
        #1;
        chk("rst_hold",    2, 32'd0, 0);
        @(negedge clk);
        reset = 1'b1;
        step("post_ctrl",  0, 0, 32'd0, 0, 32'd0, 0);
        step("post_count", 0, 0, 32'd0, 2, 32'd0, 0);
        step("post_count2",0, 0, 32'd0, 2, 32'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
